// File: rtl/shift_add_mul4_if.sv
// Request/result bundle for the shift-and-add multiplier.
// The requester drives the master side; the multiplier core is the slave.
interface shift_add_mul4_if #(
  parameter int N = 4
);
  logic             start;
  logic [N-1:0]     a;
  logic [N-1:0]     b;
  logic [2*N-1:0]   product;
  logic             busy;
  logic             done;

  modport master (output start, a, b, input product, busy, done);
  modport slave  (input start, a, b, output product, busy, done);
endinterface

// File: rtl/shift_add_mul4.sv
// Sequential unsigned shift-and-add multiplier, one partial product per clock.
// Optional macro ZERO_SKIP_EN: a zero operand completes directly from IDLE with product 0.
module shift_add_mul4 #(
  parameter int N     = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  shift_add_mul4_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [N-1:0]     m_q, m_d;
  logic [N:0]       acc_q, acc_d;
  logic [N-1:0]     q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*N-1:0]   product_q, product_d;
  logic [N:0]       sum_s;

  // Ripple-carry adder built from full-adder equations; bit N is the carry out.
  function automatic logic [N:0] rc_add(input logic [N-1:0] x, input logic [N-1:0] y);
    logic       c;
    logic [N:0] s;
    c = 1'b0;
    s = {(N+1){1'b0}};
    for (int i = 0; i < N; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    s[N] = c;
    return s;
  endfunction

  // Next-state and datapath update logic.
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    acc_d     = acc_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    sum_s     = acc_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          m_d     = bus.a;
          q_d     = bus.b;
          acc_d   = {(N+1){1'b0}};
          cnt_d   = {CNT_W{1'b0}};
          state_d = CALC;
`ifdef ZERO_SKIP_EN
          if ((bus.a == {N{1'b0}}) || (bus.b == {N{1'b0}})) begin
            state_d   = DONE;
            product_d = {(2*N){1'b0}};
          end else begin
            state_d   = CALC;
          end
`endif
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        // acc_q[N] is always 0 here because every shift refills it with 0.
        if (q_q[0]) begin
          sum_s = rc_add(acc_q[N-1:0], m_q);
        end else begin
          sum_s = acc_q;
        end
        acc_d = {1'b0, sum_s[N:1]};
        q_d   = {sum_s[0], q_q[N-1:1]};
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == LAST_CNT) begin
          product_d = {acc_d[N-1:0], q_d};
          state_d   = DONE;
        end else begin
          state_d   = CALC;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      m_q       <= {N{1'b0}};
      acc_q     <= {(N+1){1'b0}};
      q_q       <= {N{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      product_q <= {(2*N){1'b0}};
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign bus.product = product_q;
  assign bus.busy    = (state_q == CALC) || (state_q == DONE);
  assign bus.done    = (state_q == DONE);

endmodule

// File: tb/tb_shift_add_mul4.sv
// Directed self-checking bench for shift_add_mul4; honours ZERO_SKIP_EN when defined.
module tb_shift_add_mul4;

  logic clk = 1'b0;
  logic rst;
  int   tests_run    = 0;
  int   tests_failed = 0;

`ifdef ZERO_SKIP_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 5;
`endif

  always #5 clk = ~clk;

  shift_add_mul4_if #(.N(4)) bus ();

  shift_add_mul4 #(.N(4), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Starts an op at #1 after an edge in IDLE; returns cycles until done (1 = cycle after accept).
  task automatic run_op(input logic [3:0] aa, input logic [3:0] bb,
                        output int lat, output int busy_cnt, output logic [7:0] prod);
    bus.a     = aa;
    bus.b     = bb;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat       = 1;
    busy_cnt  = 0;
    while (bus.done !== 1'b1 && lat < 30) begin
      if (bus.busy === 1'b1) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    if (bus.busy === 1'b1) busy_cnt++;
    prod = bus.product;
  endtask

  task automatic test_reset();
    rst = 1'b0; bus.start = 1'b0; bus.a = 4'd0; bus.b = 4'd0;
    #1;
    tests_run++;
    if ({bus.product, bus.busy, bus.done} !== 10'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got product=%0h busy=%b done=%b, expected 0 0 0",
               bus.product, bus.busy, bus.done);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if ({bus.product, bus.busy, bus.done} !== 10'b0) begin
      tests_failed++;
      $display("FAIL reset_release_idle: got product=%0h busy=%b done=%b, expected 0 0 0",
               bus.product, bus.busy, bus.done);
    end
  endtask

  task automatic test_basic();
    int lat; int bc; logic [7:0] p;
    run_op(4'd13, 4'd11, lat, bc, p);
    tests_run++;
    if (lat !== 5) begin tests_failed++; $display("FAIL basic_latency: got %0d expected 5", lat); end
    tests_run++;
    if (bc !== 5) begin tests_failed++; $display("FAIL basic_busy_cycles: got %0d expected 5", bc); end
    tests_run++;
    if (p !== 8'h8F) begin tests_failed++; $display("FAIL basic_product: got %0h expected 8f", p); end
    @(posedge clk); #1;
    tests_run++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.product !== 8'h8F) begin
      tests_failed++;
      $display("FAIL basic_hold: got done=%b busy=%b product=%0h expected 0 0 8f",
               bus.done, bus.busy, bus.product);
    end
  endtask

  task automatic test_vectors();
    logic [3:0] va [3] = '{4'd15, 4'd1, 4'd6};
    logic [3:0] vb [3] = '{4'd15, 4'd1, 4'd7};
    logic [7:0] vp [3] = '{8'hE1, 8'h01, 8'h2A};
    int lat; int bc; logic [7:0] p;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], lat, bc, p);
      @(posedge clk); #1;
      tests_run++;
      if (p !== vp[i] || lat !== 5) begin
        tests_failed++;
        $display("FAIL vector_%0d: got product=%0h lat=%0d expected %0h lat=5", i, p, lat, vp[i]);
      end
    end
  endtask

  task automatic test_zero();
    int lat; int bc; logic [7:0] p;
    run_op(4'd0, 4'd9, lat, bc, p);
    @(posedge clk); #1;
    tests_run++;
    if (p !== 8'h00 || lat !== ZLAT) begin
      tests_failed++;
      $display("FAIL zero_a: got product=%0h lat=%0d expected 0 lat=%0d", p, lat, ZLAT);
    end
    run_op(4'd5, 4'd0, lat, bc, p);
    @(posedge clk); #1;
    tests_run++;
    if (p !== 8'h00 || lat !== ZLAT) begin
      tests_failed++;
      $display("FAIL zero_b: got product=%0h lat=%0d expected 0 lat=%0d", p, lat, ZLAT);
    end
  endtask

  task automatic test_exhaustive();
    int lat; int bc; logic [7:0] p; logic [3:0] x; logic [3:0] y; int elat; int bad;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        x = 4'(i); y = 4'(j);
        elat = (i == 0 || j == 0) ? ZLAT : 5;
        run_op(x, y, lat, bc, p);
        @(posedge clk); #1;
        tests_run++;
        if (p !== 8'(i * j) || lat !== elat) begin
          tests_failed++;
          if (bad < 8) $display("FAIL sweep_%0dx%0d: got product=%0h lat=%0d expected %0h lat=%0d",
                                i, j, p, lat, 8'(i * j), elat);
          bad++;
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat; int gap;
    bus.a = 4'd3; bus.b = 4'd5; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.a = 4'd7; bus.b = 4'd9;
    lat = 1;
    while (bus.done !== 1'b1 && lat < 30) begin @(posedge clk); #1; lat++; end
    tests_run++;
    if (lat !== 5 || bus.product !== 8'h0F) begin
      tests_failed++;
      $display("FAIL b2b_first: got product=%0h lat=%0d expected f lat=5", bus.product, lat);
    end
    gap = 0;
    do begin @(posedge clk); #1; gap++; end while (bus.done !== 1'b1 && gap < 30);
    bus.start = 1'b0;
    tests_run++;
    if (gap !== 6 || bus.product !== 8'h3F) begin
      tests_failed++;
      $display("FAIL b2b_second: got product=%0h spacing=%0d expected 3f spacing=6", bus.product, gap);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    tests_run++;
    if (bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_no_third: got busy=%b expected 0", bus.busy);
    end
  endtask

  task automatic test_ignored_start();
    int lat; int extra;
    bus.a = 4'd2; bus.b = 4'd3; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    bus.a = 4'd15; bus.b = 4'd15; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 3;
    while (bus.done !== 1'b1 && lat < 30) begin @(posedge clk); #1; lat++; end
    tests_run++;
    if (lat !== 5 || bus.product !== 8'h06) begin
      tests_failed++;
      $display("FAIL calc_start_ignored: got product=%0h lat=%0d expected 6 lat=5", bus.product, lat);
    end
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    extra = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.busy === 1'b1 || bus.done === 1'b1) extra++;
      @(posedge clk); #1;
    end
    tests_run++;
    if (extra !== 0 || bus.product !== 8'h06) begin
      tests_failed++;
      $display("FAIL done_start_ignored: got %0d active cycles product=%0h expected 0 and 6",
               extra, bus.product);
    end
  endtask

  task automatic test_async_reset();
    int lat; int bc; int extra; logic [7:0] p;
    bus.a = 4'd5; bus.b = 4'd5; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    #2 rst = 1'b0;
    #1;
    tests_run++;
    if ({bus.product, bus.busy, bus.done} !== 10'b0) begin
      tests_failed++;
      $display("FAIL async_reset: got product=%0h busy=%b done=%b expected 0 0 0",
               bus.product, bus.busy, bus.done);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    extra = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.busy === 1'b1 || bus.done === 1'b1) extra++;
      @(posedge clk); #1;
    end
    tests_run++;
    if (extra !== 0) begin
      tests_failed++;
      $display("FAIL reset_abort: got %0d active cycles expected 0", extra);
    end
    run_op(4'd6, 4'd7, lat, bc, p);
    tests_run++;
    if (p !== 8'h2A || lat !== 5) begin
      tests_failed++;
      $display("FAIL post_reset_op: got product=%0h lat=%0d expected 2a lat=5", p, lat);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_zero();
    test_exhaustive();
    test_back_to_back();
    test_ignored_start();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
